kf_op_seq: RTL and testbench

Microcoded operation sequencer that sits directly upstream of the data-bank / RQ / RD register block. It fetches 21-bit instructions from an external program store and drives the register block's two read ports. It hands operand pairs to the arithmetic unit over a req/gnt + done handshake and writes results back through the register block's write port. It is also the only writer of RQ and RD.

---
 rtl/kf_seq_pkg.sv | 31 +++
 rtl/kf_seq_decode.sv | 28 ++
 rtl/kf_op_seq.sv | 217 +++++++++++++++++++++
 tb/tb_kf_op_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_seq_pkg.sv
// Shared definitions for the kf_op_seq operation sequencer: opcodes,
// instruction field layout and FSM state encoding.
package kf_seq_pkg;

    // Instruction word: [20:18] op, [17:12] dst, [11:6] srca, [5:0] srcb
    localparam int INSTR_W  = 21;
    localparam int FIELD_W  = 6;
    localparam int OP_LSB   = 18;
    localparam int DST_LSB  = 12;
    localparam int SRCA_LSB = 6;
    localparam int SRCB_LSB = 0;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_MOVQ = 3'd4;
    localparam logic [2:0] OP_MOVD = 3'd5;
    localparam logic [2:0] OP_NOP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/kf_seq_decode.sv
// Combinational instruction decoder: splits the instruction register into
// its fields and classifies the opcode.
module kf_seq_decode
    import kf_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         op,
    output logic [FIELD_W-1:0] dst,
    output logic [FIELD_W-1:0] srca,
    output logic [FIELD_W-1:0] srcb,
    output logic               is_alu,
    output logic               is_movq,
    output logic               is_movd,
    output logic               is_halt
);

    assign op   = ir[OP_LSB   +: 3];
    assign dst  = ir[DST_LSB  +: FIELD_W];
    assign srca = ir[SRCA_LSB +: FIELD_W];
    assign srcb = ir[SRCB_LSB +: FIELD_W];

    // ADD/SUB/MUL/DIV occupy opcodes 0..3, so the MSB alone selects the ALU
    assign is_alu  = (op[2] == 1'b0);
    assign is_movq = (op == OP_MOVQ);
    assign is_movd = (op == OP_MOVD);
    assign is_halt = (op == OP_HALT);

endmodule

// File: rtl/kf_op_seq.sv
// Microcoded operation sequencer driving the data-bank / RQ / RD register
// block and the arithmetic unit. Optional ALU-done watchdog is enabled by
// defining KF_SEQ_TIMEOUT_EN.
module kf_op_seq
    import kf_seq_pkg::*;
#(
    parameter int W       = 24,
    parameter int ADDRW   = 6,
    parameter int PCW     = 8,
    parameter int TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PCW-1:0]     instr_addr,
    input  logic [INSTR_W-1:0] instr_rdata,
    output logic [ADDRW-1:0]   db_raddr_a,
    output logic [ADDRW-1:0]   db_raddr_b,
    input  logic [W-1:0]       db_rdata_a,
    input  logic [W-1:0]       db_rdata_b,
    output logic               db_we,
    output logic [ADDRW-1:0]   db_waddr,
    output logic [W-1:0]       db_wdata,
    output logic               rq_we,
    output logic               rd_we,
    output logic [W-1:0]       rq_d,
    output logic [W-1:0]       rd_d,
    output logic               alu_req,
    output logic [1:0]         alu_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    input  logic               alu_gnt,
    input  logic               alu_done,
    input  logic [W-1:0]       alu_result
);

    state_t             state;
    logic [PCW-1:0]     pc;
    logic [INSTR_W-1:0] ir;
    logic [W-1:0]       res_q;
    logic               err_q;

    logic [2:0]         op;
    logic [FIELD_W-1:0] dst, srca, srcb;
    logic               is_alu, is_movq, is_movd, is_halt;
    logic               pc_last;

    kf_seq_decode u_decode (
        .ir      (ir),
        .op      (op),
        .dst     (dst),
        .srca    (srca),
        .srcb    (srcb),
        .is_alu  (is_alu),
        .is_movq (is_movq),
        .is_movd (is_movd),
        .is_halt (is_halt)
    );

    // Opcode MSB is already folded into the is_* flags
    logic unused_op_msb;
    assign unused_op_msb = op[2];

    // Last program slot: advancing from here is an overrun, pc never wraps
    assign pc_last = (pc == {PCW{1'b1}});

`ifdef KF_SEQ_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // tmo_cnt is 0 in the first WAIT cycle, so the last allowed cycle is TMO_CYC-1
    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
`endif

    // Sequencer FSM: program counter, instruction register and sticky error
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            err_q <= 1'b0;
`ifdef KF_SEQ_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        err_q <= 1'b0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir    <= instr_rdata;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_alu) begin
                        if (alu_gnt) begin
                            state <= ST_WAIT;
`ifdef KF_SEQ_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end else if (is_halt) begin
                        state <= ST_DONE;
                    end else if (pc_last) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        state <= ST_WB;
                    end
`ifdef KF_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_WB: begin
                    if (pc_last) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the ALU result for the write-back cycle
    always_ff @(posedge clk) begin
        // NOTE: res_q has no reset; it is only visible through db_wdata in WB,
        // which is unreachable until a fresh result has been captured.
        if (state == ST_WAIT && alu_done) begin
            res_q <= alu_result;
        end
    end

    assign instr_addr = pc;
    assign err        = err_q;

    // Output decode from state and ir; rst forces every strobe low in its cycle
    always_comb begin
        // NOTE: every output is defaulted first so no path leaves one unassigned
        // and no latch is inferred.
        busy       = 1'b0;
        done       = 1'b0;
        db_raddr_a = '0;
        db_raddr_b = '0;
        db_we      = 1'b0;
        db_waddr   = '0;
        db_wdata   = '0;
        rq_we      = 1'b0;
        rd_we      = 1'b0;
        rq_d       = '0;
        rd_d       = '0;
        alu_req    = 1'b0;
        alu_op     = 2'b00;
        alu_a      = '0;
        alu_b      = '0;
        if (!rst) begin
            db_raddr_a = ADDRW'(srca);
            db_raddr_b = ADDRW'(srcb);
            case (state)
                ST_FETCH, ST_WAIT: busy = 1'b1;
                ST_EXEC: begin
                    busy = 1'b1;
                    if (is_alu) begin
                        alu_req = 1'b1;
                        alu_op  = op[1:0];
                        alu_a   = db_rdata_a;
                        alu_b   = db_rdata_b;
                    end
                    if (is_movq) begin
                        rq_we = 1'b1;
                        rq_d  = db_rdata_a;
                    end
                    if (is_movd) begin
                        rd_we = 1'b1;
                        rd_d  = db_rdata_a;
                    end
                end
                ST_WB: begin
                    busy     = 1'b1;
                    db_we    = 1'b1;
                    db_waddr = ADDRW'(dst);
                    db_wdata = res_q;
                end
                ST_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kf_op_seq.sv
// Directed testbench for kf_op_seq. Timeout scenario runs only when
// KF_SEQ_TIMEOUT_EN is defined (DUT built with TMO_CYC=10).
module tb_kf_op_seq;
    import kf_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, err;
    logic [7:0]  instr_addr;
    logic [20:0] instr_rdata;
    logic [5:0]  db_raddr_a, db_raddr_b, db_waddr;
    logic [23:0] db_rdata_a, db_rdata_b, db_wdata;
    logic        db_we, rq_we, rd_we;
    logic [23:0] rq_d, rd_d;
    logic        alu_req;
    logic [1:0]  alu_op;
    logic [23:0] alu_a, alu_b;
    logic        alu_gnt, alu_done;
    logic [23:0] alu_result;

    logic [20:0] prog [0:255];
    logic [23:0] bank [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kf_op_seq #(.W(24), .ADDRW(6), .PCW(8), .TMO_CYC(10)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .instr_addr(instr_addr), .instr_rdata(instr_rdata),
        .db_raddr_a(db_raddr_a), .db_raddr_b(db_raddr_b),
        .db_rdata_a(db_rdata_a), .db_rdata_b(db_rdata_b),
        .db_we(db_we), .db_waddr(db_waddr), .db_wdata(db_wdata),
        .rq_we(rq_we), .rd_we(rd_we), .rq_d(rq_d), .rd_d(rd_d),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_gnt(alu_gnt), .alu_done(alu_done), .alu_result(alu_result)
    );

    // Program store and register block models
    assign instr_rdata = prog[instr_addr];
    assign db_rdata_a  = bank[db_raddr_a];
    assign db_rdata_b  = bank[db_raddr_b];
    always @(posedge clk) if (db_we) bank[db_waddr] <= db_wdata;

    // ALU model: grants after gnt_delay request cycles, answers done_delay
    // cycles after the first WAIT cycle
    int          gnt_delay = 0, done_delay = 0, req_cnt = 0, dcnt = 0;
    bit          pend = 1'b0;
    logic [1:0]  m_op;
    logic [23:0] m_a, m_b;
    initial begin alu_gnt = 1'b0; alu_done = 1'b0; alu_result = '0; end
    always @(negedge clk) begin
        alu_gnt  = 1'b0;
        alu_done = 1'b0;
        if (pend) begin
            if (dcnt == done_delay) begin
                alu_done = 1'b1;
                case (m_op)
                    2'd0: alu_result = m_a + m_b;
                    2'd1: alu_result = m_a - m_b;
                    2'd2: alu_result = m_a * m_b;
                    default: alu_result = (m_b == 0) ? 24'hFFFFFF : m_a / m_b;
                endcase
                pend = 1'b0;
            end else dcnt++;
        end else if (alu_req) begin
            if (req_cnt == gnt_delay) begin
                alu_gnt = 1'b1;
                pend    = 1'b1;
                dcnt    = 0;
                req_cnt = 0;
                m_op = alu_op; m_a = alu_a; m_b = alu_b;
            end else req_cnt++;
        end
    end

    function automatic logic [20:0] enc(input logic [2:0] op, input int d, input int a, input int b);
        return {op, 6'(d), 6'(a), 6'(b)};
    endfunction

    // Per-run observations, indexed by cycle (0 = FETCH of pc 0)
    int we_cnt, we_idx, rq_cnt, rq_idx, rd_cnt, rd_idx, done_cnt, done_idx;
    int excl_bad, busy_bad, req_cycles, req_bad, max_pc;
    logic [5:0]  we_addr;
    logic [23:0] we_data, rq_v, rd_v;
    logic        err_first, err_done;
    bit          left0, pc_ret0;
    logic [1:0]  r_op;
    logic [23:0] r_a, r_b;

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_prog(input int max_cyc, input bit pulse_mid);
        we_cnt = 0; rq_cnt = 0; rd_cnt = 0; done_cnt = 0; done_idx = -1;
        we_idx = -1; rq_idx = -1; rd_idx = -1; excl_bad = 0; busy_bad = 0;
        req_cycles = 0; req_bad = 0; max_pc = 0; left0 = 0; pc_ret0 = 0;
        err_first = 1'bx; err_done = 1'bx;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (i == 0) err_first = err;
            if (db_we) begin
                we_cnt++;
                if (we_cnt == 1) begin we_idx = i; we_addr = db_waddr; we_data = db_wdata; end
            end
            if (rq_we) begin rq_cnt++; if (rq_cnt == 1) begin rq_idx = i; rq_v = rq_d; end end
            if (rd_we) begin rd_cnt++; if (rd_cnt == 1) begin rd_idx = i; rd_v = rd_d; end end
            if (int'(db_we) + int'(rq_we) + int'(rd_we) > 1) excl_bad++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin done_idx = i; err_done = err; end
                if (busy) busy_bad++;
            end
            if (alu_req) begin
                if (req_cycles == 0) begin r_op = alu_op; r_a = alu_a; r_b = alu_b; end
                else if (alu_op !== r_op || alu_a !== r_a || alu_b !== r_b) req_bad++;
                req_cycles++;
            end
            if (busy) begin
                if (instr_addr != 0) left0 = 1;
                else if (left0) pc_ret0 = 1;
                if (int'(instr_addr) > max_pc) max_pc = int'(instr_addr);
            end
            if (done_cnt > 0 && i >= done_idx + 3) break;
            start = pulse_mid && (i == 3 || i == 8);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, done, err, db_we, rq_we, rd_we, alu_req} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000", {busy, done, err, db_we, rq_we, rd_we, alu_req});
        end
        n_checks++;
        if ({instr_addr, db_raddr_a, db_raddr_b, db_waddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_addrs: got %h want 0", {instr_addr, db_raddr_a, db_raddr_b, db_waddr});
        end
        n_checks++;
        if ({db_wdata, rq_d, rd_d, alu_a, alu_b, alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {db_wdata, rq_d, rd_d, alu_a, alu_b, alu_op});
        end
    endtask

    task automatic test_add();
        prog[0] = enc(OP_ADD, 5, 1, 2);
        prog[1] = enc(OP_HALT, 0, 0, 0);
        bank[1] = 24'd3; bank[2] = 24'd4;
        gnt_delay = 0; done_delay = 0;
        run_prog(40, 1'b0);
        n_checks++;
        if (we_idx !== 3) begin n_fail++; $display("FAIL add_wb_cycle: got %0d want 3", we_idx); end
        n_checks++;
        if (we_cnt !== 1 || we_addr !== 6'd5 || we_data !== 24'd7) begin
            n_fail++;
            $display("FAIL add_wb: got cnt=%0d addr=%0d data=%0h want cnt=1 addr=5 data=7", we_cnt, we_addr, we_data);
        end
        n_checks++;
        if (r_a !== 24'd3 || r_b !== 24'd4 || r_op !== 2'd0) begin
            n_fail++;
            $display("FAIL add_operands: got op=%0d a=%0h b=%0h want op=0 a=3 b=4", r_op, r_a, r_b);
        end
        n_checks++;
        if (done_cnt !== 1 || done_idx !== 6 || err_done !== 1'b0 || busy_bad !== 0) begin
            n_fail++;
            $display("FAIL add_done: got cnt=%0d idx=%0d err=%b busy_at_done=%0d want 1 6 0 0", done_cnt, done_idx, err_done, busy_bad);
        end
    endtask

    task automatic test_mov();
        prog[0] = enc(OP_MOVQ, 0, 9, 0);
        prog[1] = enc(OP_MOVD, 0, 10, 0);
        prog[2] = enc(OP_HALT, 0, 0, 0);
        bank[9] = 24'h00ABCD; bank[10] = 24'h123456;
        run_prog(40, 1'b0);
        n_checks++;
        if (rq_cnt !== 1 || rq_idx !== 1 || rq_v !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL movq: got cnt=%0d idx=%0d d=%h want 1 1 00abcd", rq_cnt, rq_idx, rq_v);
        end
        n_checks++;
        if (rd_cnt !== 1 || rd_idx !== 3 || rd_v !== 24'h123456) begin
            n_fail++;
            $display("FAIL movd: got cnt=%0d idx=%0d d=%h want 1 3 123456", rd_cnt, rd_idx, rd_v);
        end
        n_checks++;
        if (we_cnt !== 0 || excl_bad !== 0 || done_idx !== 6) begin
            n_fail++;
            $display("FAIL mov_misc: got we=%0d excl=%0d done_idx=%0d want 0 0 6", we_cnt, excl_bad, done_idx);
        end
    endtask

    task automatic test_mul_stall();
        prog[0] = enc(OP_MUL, 7, 3, 4);
        prog[1] = enc(OP_HALT, 0, 0, 0);
        bank[3] = 24'h000123; bank[4] = 24'h000045;
        gnt_delay = 3; done_delay = 5;
        run_prog(60, 1'b1);
        n_checks++;
        if (req_cycles !== 4 || req_bad !== 0 || r_op !== 2'd2) begin
            n_fail++;
            $display("FAIL mul_req_hold: got cycles=%0d unstable=%0d op=%0d want 4 0 2", req_cycles, req_bad, r_op);
        end
        n_checks++;
        if (we_cnt !== 1 || we_idx !== 11 || we_addr !== 6'd7 || we_data !== 24'h004E6F) begin
            n_fail++;
            $display("FAIL mul_wb: got cnt=%0d idx=%0d addr=%0d data=%h want 1 11 7 004e6f", we_cnt, we_idx, we_addr, we_data);
        end
        n_checks++;
        if (done_cnt !== 1 || done_idx !== 14 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_start_ignored: got done_cnt=%0d idx=%0d busy=%b want 1 14 0", done_cnt, done_idx, busy);
        end
        gnt_delay = 0; done_delay = 0;
    endtask

    task automatic test_pc_overflow();
        for (int i = 0; i < 256; i++) prog[i] = enc(OP_NOP, 0, 0, 0);
        run_prog(600, 1'b0);
        n_checks++;
        if (done_cnt !== 1 || done_idx !== 512 || err_done !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_err: got cnt=%0d idx=%0d err=%b want 1 512 1", done_cnt, done_idx, err_done);
        end
        n_checks++;
        if (pc_ret0 !== 1'b0 || max_pc !== 255) begin
            n_fail++;
            $display("FAIL overflow_pc: got returned0=%b max_pc=%0d want 0 255", pc_ret0, max_pc);
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_err_clear();
        prog[0] = enc(OP_ADD, 6, 1, 2);
        prog[1] = enc(OP_HALT, 0, 0, 0);
        run_prog(40, 1'b0);
        n_checks++;
        if (err_first !== 1'b0 || err_done !== 1'b0 || we_data !== 24'd7) begin
            n_fail++;
            $display("FAIL err_clear: got err0=%b err_done=%b data=%0h want 0 0 7", err_first, err_done, we_data);
        end
    endtask

    task automatic test_reset_in_wait();
        int bad = 0;
        bit got_gnt = 0;
        bank[6] = 24'h0;
        prog[0] = enc(OP_ADD, 6, 1, 2);
        prog[1] = enc(OP_HALT, 0, 0, 0);
        gnt_delay = 0; done_delay = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20 && !got_gnt; i++) begin
            @(negedge clk);
            if (alu_gnt) got_gnt = 1;
        end
        n_checks++;
        if (!got_gnt) begin n_fail++; $display("FAIL rstwait_gnt: got no grant want grant"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({busy, done, db_we, rq_we, rd_we, alu_req} !== 6'b0 || instr_addr !== 8'd0
                || db_wdata !== 24'd0 || dut.state !== ST_IDLE) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0 || bank[6] !== 24'h0) begin
            n_fail++;
            $display("FAIL rstwait_abort: got bad_cycles=%0d bank6=%h want 0 000000", bad, bank[6]);
        end
        done_delay = 0;
        run_prog(40, 1'b0);
        n_checks++;
        if (we_cnt !== 1 || we_idx !== 3 || we_data !== 24'd7 || done_idx !== 6) begin
            n_fail++;
            $display("FAIL rstwait_rerun: got cnt=%0d idx=%0d data=%0h done=%0d want 1 3 7 6", we_cnt, we_idx, we_data, done_idx);
        end
    endtask

`ifdef KF_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        prog[0] = enc(OP_ADD, 8, 1, 2);
        prog[1] = enc(OP_HALT, 0, 0, 0);
        gnt_delay = 0; done_delay = 12;
        run_prog(60, 1'b0);
        n_checks++;
        if (done_idx !== 12 || err_done !== 1'b1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_done: got idx=%0d err=%b cnt=%0d want 12 1 1", done_idx, err_done, done_cnt);
        end
        n_checks++;
        if (we_cnt !== 0) begin n_fail++; $display("FAIL timeout_no_wb: got %0d want 0", we_cnt); end
        done_delay = 0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) bank[i] = '0;
        for (int i = 0; i < 256; i++) prog[i] = enc(OP_HALT, 0, 0, 0);
        test_reset();
        test_add();
        test_mov();
        test_mul_stall();
        test_pc_overflow();
        test_err_clear();
        test_reset_in_wait();
`ifdef KF_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
